axi_burst_gen: RTL and testbench



---
 rtl/axi_burst_gen.sv | 133 +++++++++++++
 tb/tb_axi_burst_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_gen.sv
// AXI initiator address generator: splits a byte-granular transfer command
// into INCR bursts that respect the 4 KB boundary and the per-burst beat limit.
module axi_burst_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_bytes,
  output logic                  ax_valid,
  input  logic                  ax_ready,
  output logic [ADDR_WIDTH-1:0] ax_addr,
  output logic [7:0]            ax_len,
  output logic [2:0]            ax_size,
  output logic [1:0]            ax_burst,
  output logic                  ax_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam int BPB       = DATA_WIDTH / 8;
  localparam int DATA_SIZE = $clog2(BPB);
  // Wide enough for rem_bytes plus offset rounding and a full 4 KB span.
  localparam int CW        = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 2;
  localparam logic [11:0] OFF_MASK = 12'(BPB - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_bytes_q, rem_bytes_d;
  logic [ADDR_WIDTH-1:0] ax_addr_q, ax_addr_d;
  logic [7:0]            ax_len_q, ax_len_d;
  logic                  ax_last_q, ax_last_d;
  logic                  done_q, done_d;

  logic [CW-1:0] off, rem_ext, beats_rem, beats_4k, beats_calc, span_calc;
  logic [CW-1:0] beats_iss, xfer_iss;
  logic [12:0]   line_base;

  always_comb begin
    off        = CW'(cur_addr_q[11:0] & OFF_MASK);
    rem_ext    = CW'(rem_bytes_q);
    beats_rem  = (off + rem_ext + CW'(BPB - 1)) >> DATA_SIZE;
    line_base  = {1'b0, cur_addr_q[11:0] & ~OFF_MASK};
    beats_4k   = CW'((13'h1000 - line_base) >> DATA_SIZE);
    beats_calc = (beats_rem < beats_4k) ? beats_rem : beats_4k;
    if (beats_calc > CW'(MAX_BEATS)) beats_calc = CW'(MAX_BEATS);
    span_calc  = beats_calc << DATA_SIZE;
    // The issued burst length is the registered ax_len, not a recomputation.
    beats_iss  = CW'(ax_len_q) + CW'(1);
    xfer_iss   = (beats_iss << DATA_SIZE) - off;
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_bytes_d = rem_bytes_q;
    ax_addr_d   = ax_addr_q;
    ax_len_d    = ax_len_q;
    ax_last_d   = ax_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          rem_bytes_d = cmd_bytes;
          if (cmd_bytes == '0) done_d = 1'b1;
          else state_d = CALC;
        end
      end
      CALC: begin
        ax_addr_d = cur_addr_q;
        ax_len_d  = 8'(beats_calc - CW'(1));
        ax_last_d = (span_calc - off) >= rem_ext;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (ax_ready) begin
          cur_addr_d  = (cur_addr_q & ~ADDR_WIDTH'(BPB - 1))
                      + ADDR_WIDTH'(beats_iss << DATA_SIZE);
          rem_bytes_d = (xfer_iss >= rem_ext) ? '0
                      : rem_bytes_q - LEN_WIDTH'(xfer_iss);
          if (ax_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_bytes_q <= '0;
      ax_addr_q   <= '0;
      ax_len_q    <= '0;
      ax_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_bytes_q <= rem_bytes_d;
      ax_addr_q   <= ax_addr_d;
      ax_len_q    <= ax_len_d;
      ax_last_q   <= ax_last_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ax_valid  = (state_q == ISSUE);
  assign ax_addr   = ax_addr_q;
  assign ax_len    = ax_len_q;
  assign ax_size   = 3'(DATA_SIZE);
  assign ax_burst  = 2'b01;
  assign ax_last   = ax_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_axi_burst_gen.sv
// Scoreboard bench for axi_burst_gen: directed commands push expected bursts,
// a monitor pops and compares on every address-channel handshake.
module tb_axi_burst_gen;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmdValid = 1'b0;
  logic [31:0] cmdAddr = '0;
  logic [15:0] cmdBytes = '0;
  logic        axReady = 1'b1;

  logic        cmd_ready, ax_valid, ax_last, busy, done;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;

  int     checkCount = 0;
  int     errorCount = 0;
  int     doneSeen = 0;
  int     doneExp = 0;
  burst_t expQ[$];
  burst_t monExp;

  axi_burst_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_BEATS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmdValid), .cmd_ready(cmd_ready),
    .cmd_addr(cmdAddr), .cmd_bytes(cmdBytes),
    .ax_valid(ax_valid), .ax_ready(axReady),
    .ax_addr(ax_addr), .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst),
    .ax_last(ax_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Shared compare helper; automatic because the monitor and the directed
  // sequence may call it in the same time step.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    errorCount++;
    $display("[TB] FAIL %s: timed out, got no response, expected one", name);
  endtask

  task automatic pushBurst(input logic [31:0] a, input logic [7:0] l, input logic last);
    burst_t b;
    b.addr = a;
    b.len  = l;
    b.last = last;
    expQ.push_back(b);
  endtask

  // Presents a command and returns at the falling edge after it was accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b, input bit expectDone);
    int n = 0;
    @(negedge clk);
    cmdValid = 1'b1;
    cmdAddr  = a;
    cmdBytes = b;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) reportTimeout("cmd_accept");
    @(negedge clk);
    cmdValid = 1'b0;
    if (expectDone) doneExp++;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || expQ.size() != 0) && n < 3000);
    if (busy || expQ.size() != 0) reportTimeout(name);
    repeat (2) @(negedge clk);
    checkOutput({name, "_done_count"}, 64'(doneSeen), 64'(doneExp));
  endtask

  // Monitor: samples just after the falling edge, when inputs are settled.
  always @(negedge clk) begin
    #1;
    if (rst_n && ax_valid && axReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_burst_addr", 64'(ax_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("burst_addr", 64'(ax_addr), 64'(monExp.addr));
        checkOutput("burst_len", 64'(ax_len), 64'(monExp.len));
        checkOutput("burst_last", 64'(ax_last), 64'(monExp.last));
        checkOutput("burst_size", 64'(ax_size), 64'd2);
        checkOutput("burst_type", 64'(ax_burst), 64'd1);
      end
    end
    if (done) doneSeen++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_ax_valid", 64'(ax_valid), 64'd0);
    checkOutput("rst_ax_addr", 64'(ax_addr), 64'd0);
    checkOutput("rst_ax_len", 64'(ax_len), 64'd0);
    checkOutput("rst_ax_last", 64'(ax_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single aligned burst with latency checks.
    pushBurst(32'h1000, 8'd15, 1'b1);
    applyStimulus(32'h1000, 16'd64, 1'b1);
    checkOutput("lat_calc_valid", 64'(ax_valid), 64'd0);
    checkOutput("lat_calc_busy", 64'(busy), 64'd1);
    checkOutput("lat_calc_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    checkOutput("lat_issue_valid", 64'(ax_valid), 64'd1);
    @(negedge clk);
    checkOutput("lat_done_pulse", 64'(done), 64'd1);
    checkOutput("lat_done_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    checkOutput("lat_done_drop", 64'(done), 64'd0);
    waitIdle("single");

    // 4 KB split.
    pushBurst(32'h0FF0, 8'd3, 1'b0);
    pushBurst(32'h1000, 8'd3, 1'b1);
    applyStimulus(32'h0FF0, 16'd32, 1'b1);
    waitIdle("split4k");

    // 256-beat split.
    pushBurst(32'h0000, 8'd255, 1'b0);
    pushBurst(32'h0400, 8'd255, 1'b1);
    applyStimulus(32'h0000, 16'd2048, 1'b1);
    waitIdle("split256");

    // Unaligned start.
    pushBurst(32'h2002, 8'd2, 1'b1);
    applyStimulus(32'h2002, 16'd8, 1'b1);
    waitIdle("unaligned");

    // Zero-length command.
    applyStimulus(32'h5000, 16'd0, 1'b1);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("zero_no_valid", 64'(ax_valid), 64'd0);
      @(negedge clk);
    end
    waitIdle("zero");

    // Back-pressure with a competing command held during the stall.
    axReady = 1'b0;
    pushBurst(32'h1000, 8'd15, 1'b1);
    applyStimulus(32'h1000, 16'd64, 1'b1);
    begin
      int n = 0;
      while (!ax_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!ax_valid) reportTimeout("stall_valid");
    end
    cmdValid = 1'b1;
    cmdAddr  = 32'h3000;
    cmdBytes = 16'd4;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(ax_valid), 64'd1);
      checkOutput("stall_addr", 64'(ax_addr), 64'h1000);
      checkOutput("stall_len", 64'(ax_len), 64'd15);
      checkOutput("stall_last", 64'(ax_last), 64'd1);
      checkOutput("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("stall_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    pushBurst(32'h3000, 8'd0, 1'b1);
    axReady = 1'b1;
    @(negedge clk);
    checkOutput("stall_done", 64'(done), 64'd1);
    checkOutput("stall_accept_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmdValid = 1'b0;
    doneExp++;
    checkOutput("stall_second_busy", 64'(busy), 64'd1);
    waitIdle("stall");

    // Reset while the second burst of the split case is pending.
    pushBurst(32'h0FF0, 8'd3, 1'b0);
    applyStimulus(32'h0FF0, 16'd32, 1'b0);
    begin
      int n = 0;
      while (expQ.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (expQ.size() != 0) reportTimeout("reset_first_burst");
      axReady = 1'b0;
      n = 0;
      while (!ax_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!ax_valid) reportTimeout("reset_second_valid");
    end
    checkOutput("pre_reset_addr", 64'(ax_addr), 64'h1000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(ax_valid), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    checkOutput("async_rst_ready", 64'(cmd_ready), 64'd1);
    checkOutput("async_rst_addr", 64'(ax_addr), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    axReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_ready", 64'(cmd_ready), 64'd1);
      checkOutput("post_rst_no_done", 64'(done), 64'd0);
    end
    waitIdle("reset");

    pushBurst(32'h1000, 8'd15, 1'b1);
    applyStimulus(32'h1000, 16'd64, 1'b1);
    checkOutput("post_rst_lat_calc", 64'(ax_valid), 64'd0);
    @(negedge clk);
    checkOutput("post_rst_lat_issue", 64'(ax_valid), 64'd1);
    waitIdle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
